// File: rtl/opcode_step_sequencer_if.sv
// Bus bundle between the instruction fetch side, the step decoders and the
// opcode step sequencer. The master drives the requests; the sequencer is the slave.
interface opcode_step_sequencer_if #(
    parameter int STEP_W = 5
);
    logic              OpLoad;
    logic [7:0]        DataIn;
    logic              StepAdvance;
    logic              PR_Reset_XPT;
    logic              Fetch_Req;
    logic [7:0]        Source;
    logic [7:0]        notSource;
    logic [STEP_W-1:0] XPT;
    logic [STEP_W-1:0] notXPT;
    logic [3:0]        Enable_X1;
    logic              Trap;

    modport master (
        output OpLoad, DataIn, StepAdvance, PR_Reset_XPT,
        input  Fetch_Req, Source, notSource, XPT, notXPT, Enable_X1, Trap
    );

    modport slave (
        input  OpLoad, DataIn, StepAdvance, PR_Reset_XPT,
        output Fetch_Req, Source, notSource, XPT, notXPT, Enable_X1, Trap
    );
endinterface

// File: rtl/opcode_step_sequencer.sv
// Opcode step sequencer: IDLE -> FETCH -> EXEC, counting execution steps in XPT.
// Define OPSEQ_STEP_TRAP_EN to trap on step overflow instead of saturating.
module opcode_step_sequencer #(
    parameter int STEP_W = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    opcode_step_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] XPT_MAX = '1;

    state_t            state;
    logic [7:0]        source_q;
    logic [7:0]        not_source_q;
    logic [STEP_W-1:0] xpt_q;
    logic [STEP_W-1:0] not_xpt_q;
    logic [3:0]        enable_q;
    logic              fetch_req_q;
`ifdef OPSEQ_STEP_TRAP_EN
    logic              trap_q;
`endif

    function automatic logic [3:0] decode_x1(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    // Saturating step increment; the trap build never calls it at XPT_MAX.
    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (v == XPT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            source_q     <= 8'h00;
            not_source_q <= 8'hFF;
            xpt_q        <= '0;
            not_xpt_q    <= '1;
            enable_q     <= 4'b0000;
            fetch_req_q  <= 1'b0;
`ifdef OPSEQ_STEP_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    fetch_req_q <= 1'b1;
                    enable_q    <= 4'b0000;
                end

                FETCH: begin
                    if (bus.OpLoad) begin
                        state        <= EXEC;
                        source_q     <= bus.DataIn;
                        not_source_q <= ~bus.DataIn;
                        xpt_q        <= '0;
                        not_xpt_q    <= '1;
                        enable_q     <= decode_x1(bus.DataIn[7:6]);
                        fetch_req_q  <= 1'b0;
                    end
                end

                EXEC: begin
                    // End-of-instruction wins over a step completing in the same cycle.
                    if (bus.PR_Reset_XPT) begin
                        state       <= FETCH;
                        xpt_q       <= '0;
                        not_xpt_q   <= '1;
                        enable_q    <= 4'b0000;
                        fetch_req_q <= 1'b1;
                    end else if (bus.StepAdvance) begin
`ifdef OPSEQ_STEP_TRAP_EN
                        if (xpt_q == XPT_MAX) begin
                            trap_q      <= 1'b1;
                            state       <= FETCH;
                            xpt_q       <= '0;
                            not_xpt_q   <= '1;
                            enable_q    <= 4'b0000;
                            fetch_req_q <= 1'b1;
                        end else begin
                            xpt_q     <= sat_inc(xpt_q);
                            not_xpt_q <= ~sat_inc(xpt_q);
                        end
`else
                        xpt_q     <= sat_inc(xpt_q);
                        not_xpt_q <= ~sat_inc(xpt_q);
`endif
                    end
                end

                default: begin
                    state       <= IDLE;
                    enable_q    <= 4'b0000;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Fetch_Req = fetch_req_q;
    assign bus.Source    = source_q;
    assign bus.notSource = not_source_q;
    assign bus.XPT       = xpt_q;
    assign bus.notXPT    = not_xpt_q;
    assign bus.Enable_X1 = enable_q;
`ifdef OPSEQ_STEP_TRAP_EN
    assign bus.Trap      = trap_q;
`else
    assign bus.Trap      = 1'b0;
`endif
endmodule

// File: doc/opcode_step_sequencer.md
OPCODE_STEP_SEQUENCER -- requirements
Module: opcode_step_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 5, meaning XPT step counter width.
REQ-002 SHALL have port CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port OpLoad  input  1  opcode byte valid on DataIn (fetch side).
REQ-005 SHALL have port DataIn  input  8  opcode byte from bus.
REQ-006 SHALL have port StepAdvance  input  1  current execution step complete.
REQ-007 SHALL have port PR_Reset_XPT  input  1  end-of-instruction request from decoders.
REQ-008 SHALL have port Fetch_Req  output  1  sequencer waiting for an opcode.
REQ-009 SHALL have port Source, notSource  output  8 each  latched opcode and its bitwise complement.
REQ-010 SHALL have port XPT, notXPT  output  STEP_W each  execution step count and its complement.
REQ-011 SHALL have port Enable_X1  output  4  one-hot decoder enable selected by Source[7:6].
REQ-012 SHALL have port Trap  output  1  sticky step-overflow flag (see Configuration).

Function
REQ-013 SHALL implement states IDLE, FETCH, EXEC.
REQ-014 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-015 Fetch_Req SHALL be 1 only in FETCH.
REQ-016 In FETCH with OpLoad=1, the next cycle SHALL be EXEC, with Source=DataIn and XPT=0.
REQ-017 Enable_X1[Source[7:6]] SHALL be 1 only in EXEC; all Enable_X1 bits SHALL be 0 in IDLE/FETCH.
REQ-018 In EXEC, StepAdvance=1 SHALL increment XPT by 1 at the next edge.
REQ-019 In EXEC, PR_Reset_XPT=1 SHALL produce FETCH with XPT=0 at the next edge; it SHALL take priority over a simultaneous StepAdvance.
REQ-020 OpLoad SHALL be ignored outside FETCH; PR_Reset_XPT and StepAdvance SHALL be ignored outside EXEC.
REQ-021 Source SHALL hold the last loaded opcode through FETCH until the next OpLoad.
REQ-022 notSource SHALL equal ~Source and notXPT SHALL equal ~XPT in every cycle, both registered; no combinational path from any input to any output.
REQ-023 Step overflow: in EXEC, StepAdvance when XPT=2^STEP_W-1 SHALL follow the Configuration rule.

Reset
REQ-024 RESET=1 at an edge SHALL force state IDLE, Source=0x00, notSource=0xFF, XPT=0, notXPT=all ones, Fetch_Req=0, Enable_X1=0000, Trap=0.
REQ-025 RESET SHALL override all other inputs in the same cycle, including mid-EXEC.

Configuration
REQ-026 Macro OPSEQ_STEP_TRAP_EN SHALL select the overflow behaviour.
REQ-027 With OPSEQ_STEP_TRAP_EN defined, overflow SHALL set Trap=1 (sticky until RESET), set XPT=0, and force FETCH at the next edge.
REQ-028 With OPSEQ_STEP_TRAP_EN undefined, XPT SHALL saturate at 2^STEP_W-1, the state SHALL remain EXEC, and Trap SHALL be tied to 0.

Verification
REQ-029 Reset then idle: RESET for 1 cycle -> Fetch_Req=0 for 1 cycle, then 1; Source=0x00, notSource=0xFF, Enable_X1=0000.
REQ-030 Load ALU op: in FETCH, OpLoad=1, DataIn=0x86 -> next cycle Source=0x86, notSource=0x79, XPT=0, Enable_X1=0100, Fetch_Req=0.
REQ-031 Step and end: 3 StepAdvance pulses -> XPT=3, notXPT=5'b11100; then PR_Reset_XPT=1 with StepAdvance=1 -> XPT=0, FETCH, Enable_X1=0000.
REQ-032 Ignored inputs: OpLoad=1, DataIn=0x3E during EXEC -> Source unchanged; StepAdvance=1 in FETCH -> XPT stays 0.
REQ-033 Overflow, STEP_W=5: 32 StepAdvance pulses in EXEC -> with OPSEQ_STEP_TRAP_EN: Trap=1, XPT=0, Fetch_Req=1; without it: XPT=31, state EXEC, Trap=0.
REQ-034 Reset mid-operation: RESET=1 at XPT=2 in EXEC -> next cycle IDLE, all REQ-024 values, Trap cleared.
